// File: rtl/timing_gen.sv
// 6502 instruction-cycle timing generator: one-hot T-state strobes,
// SYNC, stall indication and free-running debug counters.
module timing_gen #(
    parameter int CNT_W = 16
) (
    input  logic             PHI0,
    input  logic             _RES,
    input  logic             RDY,
    input  logic             WR,
    input  logic             TRES,
    input  logic             RMW,
    output logic             T0,
    output logic             T1,
    output logic             T2,
    output logic             T3,
    output logic             T4,
    output logic             T5,
    output logic             T6,
    output logic             SYNC,
    output logic             _ready,
    output logic [CNT_W-1:0] CYCCNT,
    output logic [CNT_W-1:0] INSTCNT
);

    typedef enum logic [6:0] {
        S_T0 = 7'b0000001,
        S_T1 = 7'b0000010,
        S_T2 = 7'b0000100,
        S_T3 = 7'b0001000,
        S_T4 = 7'b0010000,
        S_T5 = 7'b0100000,
        S_T6 = 7'b1000000
    } state_t;

    state_t state;
    state_t state_nx;
    logic   adv;

    // Writes cannot be held off, so RDY only stalls read cycles.
    assign adv    = RDY | WR;
    assign _ready = ~adv;

    always_ff @(posedge PHI0) begin
        if (!_RES) begin
            state   <= S_T0;
            CYCCNT  <= '0;
            INSTCNT <= '0;
        end else if (adv) begin
            state  <= state_nx;
            CYCCNT <= CYCCNT + CNT_W'(1);
            if (state == S_T1)
                INSTCNT <= INSTCNT + CNT_W'(1);
        end
    end

    always_comb begin
        state_nx = S_T0;
        case (state)
            S_T0: state_nx = S_T1;
            S_T1: state_nx = TRES ? S_T0 : S_T2;
            S_T2: state_nx = TRES ? S_T0 : S_T3;
            S_T3: state_nx = TRES ? S_T0 : S_T4;
            S_T4: state_nx = TRES ? S_T0 : S_T5;
            S_T5: state_nx = (!TRES && RMW) ? S_T6 : S_T0;
            S_T6: state_nx = S_T0;
            default: state_nx = S_T0;
        endcase
    end

    assign T0   = state[0];
    assign T1   = state[1];
    assign T2   = state[2];
    assign T3   = state[3];
    assign T4   = state[4];
    assign T5   = state[5];
    assign T6   = state[6];
    assign SYNC = state[1];

endmodule

// File: tb/tb_timing_gen.sv
// Directed-vector bench for timing_gen; a 4-bit counter instance
// shares the stimulus to exercise counter wrap.
module tb_timing_gen;

    logic PHI0 = 1'b0;
    logic _RES, RDY, WR, TRES, RMW;

    logic t0, t1, t2, t3, t4, t5, t6, sync, rdy_o;
    logic [15:0] cyc, inst;
    logic u0, u1, u2, u3, u4, u5, u6, usync, urdy;
    logic [3:0] cyc4, inst4;

    int checks = 0;
    int errors = 0;

    always #5 PHI0 = ~PHI0;

    timing_gen #(.CNT_W(16)) dut (
        .PHI0(PHI0), ._RES(_RES), .RDY(RDY), .WR(WR),
        .TRES(TRES), .RMW(RMW),
        .T0(t0), .T1(t1), .T2(t2), .T3(t3), .T4(t4),
        .T5(t5), .T6(t6), .SYNC(sync), ._ready(rdy_o),
        .CYCCNT(cyc), .INSTCNT(inst)
    );

    timing_gen #(.CNT_W(4)) dut4 (
        .PHI0(PHI0), ._RES(_RES), .RDY(RDY), .WR(WR),
        .TRES(TRES), .RMW(RMW),
        .T0(u0), .T1(u1), .T2(u2), .T3(u3), .T4(u4),
        .T5(u5), .T6(u6), .SYNC(usync), ._ready(urdy),
        .CYCCNT(cyc4), .INSTCNT(inst4)
    );

    typedef struct {
        logic       res_n;
        logic       rdy;
        logic       wr;
        logic       tres;
        logic       rmw;
        int         st;
        logic       ready;
        logic [15:0] cyc;
        logic [15:0] inst;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [6:0] tvec();
        return {t6, t5, t4, t3, t2, t1, t0};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(logic r, logic y, logic w, logic tr, logic rm,
                       int st, logic rd, int c, int n);
        vec_t v;
        v.res_n = r; v.rdy = y; v.wr = w; v.tres = tr; v.rmw = rm;
        v.st = st; v.ready = rd;
        v.cyc = 16'(c); v.inst = 16'(n);
        vecs.push_back(v);
    endtask

    task automatic drive(logic r, logic y, logic w, logic tr, logic rm);
        _RES = r; RDY = y; WR = w; TRES = tr; RMW = rm;
    endtask

    task automatic tick();
        @(posedge PHI0);
        #1;
    endtask

    logic [6:0] exp_t;
    logic [15:0] c0;

    initial begin
        drive(0, 1, 0, 0, 0);
        // res rdy wr tres rmw | state ready cyc inst
        add(0,1,0,0,0, 0,0, 0,0);
        add(0,1,0,0,0, 0,0, 0,0);
        add(1,1,0,0,0, 1,0, 1,0);
        add(1,1,0,1,0, 0,0, 2,1);
        add(1,1,0,0,0, 1,0, 3,1);
        add(1,1,0,1,0, 0,0, 4,2);
        add(1,1,0,1,0, 1,0, 5,2);
        add(1,1,0,1,0, 0,0, 6,3);
        add(1,1,0,0,0, 1,0, 7,3);
        add(1,1,0,0,0, 2,0, 8,4);
        add(1,1,0,0,0, 3,0, 9,4);
        add(1,1,0,1,0, 0,0, 10,4);
        add(1,1,0,0,0, 1,0, 11,4);
        add(1,1,0,0,1, 2,0, 12,5);
        add(1,1,0,0,1, 3,0, 13,5);
        add(1,1,0,0,1, 4,0, 14,5);
        add(1,1,0,0,1, 5,0, 15,5);
        add(1,1,0,0,1, 6,0, 16,5);
        add(1,1,0,1,1, 0,0, 17,5);
        add(1,1,0,0,1, 1,0, 18,5);
        add(1,1,0,0,1, 2,0, 19,6);
        add(1,1,0,0,1, 3,0, 20,6);
        add(1,1,0,0,1, 4,0, 21,6);
        add(1,1,0,0,1, 5,0, 22,6);
        add(1,1,0,1,1, 0,0, 23,6);
        add(1,1,0,0,0, 1,0, 24,6);
        add(1,1,0,0,0, 2,0, 25,7);
        add(1,1,0,0,0, 3,0, 26,7);
        add(1,1,0,0,0, 4,0, 27,7);
        add(1,1,0,0,0, 5,0, 28,7);
        add(1,1,0,0,0, 0,0, 29,7);
        add(1,1,0,0,0, 1,0, 30,7);
        add(1,1,0,0,0, 2,0, 31,8);
        add(1,0,0,0,0, 2,1, 31,8);
        add(1,0,0,0,0, 2,1, 31,8);
        add(1,0,0,0,0, 2,1, 31,8);
        add(1,1,0,0,0, 3,0, 32,8);
        add(1,0,1,0,0, 4,0, 33,8);
        add(1,0,1,0,0, 5,0, 34,8);
        add(1,1,0,0,0, 0,0, 35,8);
        add(1,1,0,0,0, 1,0, 36,8);
        add(1,0,0,0,0, 1,1, 36,8);
        add(1,1,0,0,0, 2,0, 37,9);
        add(1,1,0,0,0, 3,0, 38,9);
        add(1,1,0,0,0, 4,0, 39,9);
        add(0,0,0,0,0, 0,1, 0,0);
        add(1,1,0,0,0, 1,0, 1,0);
        add(1,1,0,0,0, 2,0, 2,1);
        add(1,1,0,1,0, 0,0, 3,1);
        add(1,1,0,0,0, 1,0, 4,1);
        add(1,1,0,0,0, 2,0, 5,2);
        add(1,1,0,0,0, 3,0, 6,2);
        add(1,1,0,0,0, 4,0, 7,2);
        add(1,1,0,1,0, 0,0, 8,2);

        foreach (vecs[i]) begin
            drive(vecs[i].res_n, vecs[i].rdy, vecs[i].wr,
                  vecs[i].tres, vecs[i].rmw);
            #1;
            chk($sformatf("v%0d ready", i), 32'(rdy_o),
                32'(vecs[i].ready));
            tick();
            exp_t = 7'b1 << vecs[i].st;
            chk($sformatf("v%0d state", i), 32'(tvec()), 32'(exp_t));
            chk($sformatf("v%0d sync", i), 32'(sync), 32'(exp_t[1]));
            chk($sformatf("v%0d cyc", i), 32'(cyc), 32'(vecs[i].cyc));
            chk($sformatf("v%0d inst", i), 32'(inst), 32'(vecs[i].inst));
            chk($sformatf("v%0d cyc4", i), 32'(cyc4),
                32'(vecs[i].cyc[3:0]));
        end

        // Write cycle with RDY low advances; the following read stalls.
        c0 = cyc;
        drive(1, 0, 1, 0, 0);
        tick();
        chk("wr_adv state", 32'(tvec()), 32'(7'b0000010));
        chk("wr_adv cyc", 32'(cyc), 32'(c0 + 16'd1));
        drive(1, 0, 0, 0, 0);
        #1;
        chk("rd_stall ready", 32'(rdy_o), 32'd1);
        tick();
        chk("rd_stall state", 32'(tvec()), 32'(7'b0000010));
        chk("rd_stall cyc", 32'(cyc), 32'(c0 + 16'd1));
        chk("rd_stall inst", 32'(inst), 32'd2);
        drive(1, 1, 0, 0, 0);
        tick();
        chk("release state", 32'(tvec()), 32'(7'b0000100));
        chk("release inst", 32'(inst), 32'd3);

        // Reset wins over a pending stall in T6.
        drive(1, 1, 0, 0, 1);
        repeat (4) tick();
        chk("t6 reach", 32'(tvec()), 32'(7'b1000000));
        drive(0, 0, 0, 1, 1);
        tick();
        chk("t6 reset state", 32'(tvec()), 32'(7'b0000001));
        chk("t6 reset cyc", 32'(cyc), 32'd0);
        chk("t6 reset inst4", 32'(inst4), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/timing_gen.md
Name: timing_gen

Overview:
Instruction-cycle timing generator for the 6502 core. It produces the one-hot T-state strobes (T0, T1, T5, T6 and the intermediate T2..T4) and SYNC that the random control logic consumes. It advances on the decoder's end-of-instruction and read-modify-write indications and freezes on RDY stalls. It also maintains free-running cycle and instruction counters for debug.

Parameters:
CNT_W, 16, width of the CYCCNT and INSTCNT debug counters

Ports:
PHI0  input  1  core clock; all state updates on rising edge
_RES  input  1  synchronous active-low reset, sampled on rising PHI0
RDY  input  1  ready; low requests a stall, honoured only in read cycles
WR  input  1  current cycle is a bus write; RDY is ignored while high
TRES  input  1  from decoder: current cycle is the last execute cycle; next cycle is T0
RMW  input  1  from decoder: read-modify-write instruction; T5 extends to T6
T0  output  1  final (writeback) cycle of the instruction
T1  output  1  opcode fetch cycle
T2  output  1  timing state 2
T3  output  1  timing state 3
T4  output  1  timing state 4
T5  output  1  timing state 5
T6  output  1  RMW extra cycle
SYNC  output  1  equals T1
_ready  output  1  combinational; 1 when the current cycle is stalled (RDY=0 and WR=0)
CYCCNT  output  CNT_W  count of advancing (non-stalled) cycles
INSTCNT  output  CNT_W  count of completed opcode fetches

Behaviour:
- State register is one-hot over {T0..T6}. Exactly one of T0..T6 is 1 at every cycle after the first reset.
- Reset (_RES=0 at rising PHI0): state=T0 (T0=1, all other T outputs=0, SYNC=0), CYCCNT=0, INSTCNT=0. Reset overrides stall and every other input. Reset mid-instruction abandons the instruction.
- Advance condition: adv = RDY | WR. If adv=0, state and both counters hold, and _ready=1.
- Transitions when adv=1, in priority order:
  - T0 -> T1.
  - T1 -> T0 if TRES, else T2.
  - Tk for k=2..4 -> T0 if TRES, else Tk+1.
  - T5 -> T0 if TRES; else T6 if RMW; else T0 (maximum length without RMW).
  - T6 -> T0 unconditionally; TRES and RMW are ignored.
- TRES and RMW are ignored in T0. When TRES and RMW are both high in T5, TRES wins and the next state is T0.
- Minimum instruction length is 2 cycles (T1, T0). Maximum is 7 cycles (T1..T6, then T0).
- SYNC is T1 as a registered state decode; it carries no combinational path from inputs.
- Counters:
  - CYCCNT increments by 1 on every advancing cycle, modulo 2^CNT_W, wrapping to 0.
  - INSTCNT increments by 1 on each advancing cycle in T1 (fetch accepted), modulo 2^CNT_W, wrapping to 0.
  - Neither counter changes on a stalled cycle.
- Outputs T0..T6, SYNC, CYCCNT and INSTCNT are registered. Latency from a TRES sample to T0=1 is one cycle.
- RDY falling during a write cycle does not stall that cycle. The stall takes effect in the first read cycle where RDY is still low.

Test Plan:
- Reset then 2-cycle instruction: _RES=0 for 2 cycles, release; TRES=1 whenever state is T1 -> state sequence T0,T1,T0,T1,...; SYNC on alternate cycles; INSTCNT=3 after 6 advancing cycles.
- 4-cycle instruction: TRES=1 only in T3 -> sequence T1,T2,T3,T0,T1; CYCCNT increments by 4 per instruction.
- RMW 7-cycle: RMW=1, TRES=0 throughout -> T1,T2,T3,T4,T5,T6,T0. Same run with TRES=1 and RMW=1 in T5 -> T5 goes directly to T0.
- Stall: in T2 with WR=0, hold RDY=0 for 3 cycles -> T2 held 3 extra cycles, _ready=1 for 3 cycles, CYCCNT frozen. Repeat with WR=1 -> no stall, _ready=0.
- Counter wrap: CNT_W=4, run 17 advancing cycles from reset -> CYCCNT=1.
- Mid-op reset: assert _RES=0 in T4 with RDY=0 -> next state T0, CYCCNT=0, INSTCNT=0.
